// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch core: BCD mm:ss.cc counter with start/stop/clear buttons.
// Define STOPWATCH_LAP_EN to build the lap-hold register driven by btn_lap.
module stopwatch_bcd_counter #(
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_10ms,
    input  logic       btn_ss,
    input  logic       btn_clr,
    input  logic       btn_lap,
    output logic [7:0] bcd_cs,
    output logic [7:0] bcd_sec,
    output logic [7:0] bcd_min,
    output logic       running,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam logic [3:0] MAX_M1 = 4'(MIN_MAX / 10);
    localparam logic [3:0] MAX_M0 = 4'(MIN_MAX % 10);

`ifdef STOPWATCH_LAP_EN
    localparam int NB = 3;
    logic [NB-1:0] btn_raw;
    assign btn_raw = {btn_lap, btn_clr, btn_ss};
`else
    localparam int NB = 2;
    logic [NB-1:0] btn_raw;
    logic          unused_lap;
    assign btn_raw    = {btn_clr, btn_ss};
    assign unused_lap = btn_lap;
`endif

    logic [NB-1:0] sync1_q, sync2_q, sync3_q, ev_q;
    logic          ss_ev, clr_ev;

    // Two-flop synchronizer, then a registered rising-edge pulse per button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            ev_q    <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            ev_q    <= sync2_q & ~sync3_q;
        end
    end

    assign ss_ev  = ev_q[0];
    assign clr_ev = ev_q[1];

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;

    // Returns {carry_out, next_digit}; out-of-range digits collapse to zero.
    function automatic logic [4:0] step_digit(input logic [3:0] d,
                                              input logic [3:0] lim,
                                              input logic       cin);
        logic [4:0] r;
        if (d > lim)       r = 5'd0;
        else if (!cin)     r = {1'b0, d};
        else if (d == lim) r = {1'b1, 4'd0};
        else               r = {1'b0, d + 4'd1};
        return r;
    endfunction

    logic [3:0] cs0_adv, cs1_adv, s0_adv, s1_adv, m0_adv, m1_adv;
    logic       cy0, cy1, cy2, cy3, cy4;
    logic       min_at_max, wrap;

    always_comb begin
        {cy0, cs0_adv} = step_digit(cnt_q[3:0],   4'd9, 1'b1);
        {cy1, cs1_adv} = step_digit(cnt_q[7:4],   4'd9, cy0);
        {cy2, s0_adv}  = step_digit(cnt_q[11:8],  4'd9, cy1);
        {cy3, s1_adv}  = step_digit(cnt_q[15:12], 4'd5, cy2);
        min_at_max = (cnt_q[23:20] > MAX_M1) ||
                     ((cnt_q[23:20] == MAX_M1) && (cnt_q[19:16] >= MAX_M0));
        wrap = cy3 && min_at_max;
        {cy4, m0_adv} = step_digit(cnt_q[19:16], 4'd9, cy3 && !min_at_max);
        if (cnt_q[23:20] > 4'd9)
            m1_adv = 4'd0;
        else if (cy4)
            m1_adv = (cnt_q[23:20] == 4'd9) ? 4'd0 : cnt_q[23:20] + 4'd1;
        else
            m1_adv = cnt_q[23:20];
        if (wrap) begin
            m0_adv = 4'd0;
            m1_adv = 4'd0;
        end
    end

    // Clear wins over start/stop and over a same-cycle tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = 1'b0;
        if (clr_ev) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            if (ss_ev) begin
                case (state_q)
                    IDLE:    state_d = RUN;
                    RUN:     state_d = PAUSE;
                    PAUSE:   state_d = RUN;
                    default: state_d = IDLE;
                endcase
            end
            if (state_q == RUN && tick_10ms) begin
                cnt_d = {m1_adv, m0_adv, s1_adv, s0_adv, cs1_adv, cs0_adv};
                ovf_d = wrap;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign running = (state_q == RUN);
    assign ovf     = ovf_q;

`ifdef STOPWATCH_LAP_EN
    logic        lap_ev;
    logic        hold_vld_q;
    logic [23:0] hold_q;

    assign lap_ev = ev_q[2];

    // Lap toggles a frozen snapshot of the live count; only honoured in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else if (clr_ev) begin
            hold_vld_q <= 1'b0;
        end else if (lap_ev && state_q == RUN) begin
            if (hold_vld_q) begin
                hold_vld_q <= 1'b0;
            end else begin
                hold_vld_q <= 1'b1;
                hold_q     <= cnt_q;
            end
        end
    end

    assign {bcd_min, bcd_sec, bcd_cs} = hold_vld_q ? hold_q : cnt_q;
`else
    assign {bcd_min, bcd_sec, bcd_cs} = cnt_q;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Testbench for stopwatch_bcd_counter; MIN_MAX=1 keeps the wrap reachable quickly.
// Lap checks run only when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_bcd_counter;

    localparam int MINMAX = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_10ms = 1'b0;
    logic       btn_ss = 1'b0;
    logic       btn_clr = 1'b0;
    logic       btn_lap = 1'b0;
    logic [7:0] bcd_cs, bcd_sec, bcd_min;
    logic       running, ovf;

    stopwatch_bcd_counter #(.MIN_MAX(MINMAX)) dut (
        .clk(clk), .rst(rst), .tick_10ms(tick_10ms),
        .btn_ss(btn_ss), .btn_clr(btn_clr), .btn_lap(btn_lap),
        .bcd_cs(bcd_cs), .bcd_sec(bcd_sec), .bcd_min(bcd_min),
        .running(running), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] min, sec, cs;
        logic       run, ovf;
    } exp_t;

    typedef enum {ACT_TICKS, ACT_SS, ACT_CLR} act_e;

    typedef struct {
        act_e       act;
        int         n;
        logic [7:0] min, sec, cs;
        logic       run;
    } vec_t;

    exp_t expQ[$];
    vec_t vecs[11];
    int   compared = 0;
    int   mismatched = 0;

    task automatic expectNow(input string name, input logic [7:0] mn, input logic [7:0] sc,
                             input logic [7:0] cs, input logic run, input logic ov);
        exp_t e;
        e.name = name; e.min = mn; e.sec = sc; e.cs = cs; e.run = run; e.ovf = ov;
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        compared++;
        if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard: queue empty, required an entry");
            return;
        end
        e = expQ.pop_front();
        if ({bcd_min, bcd_sec, bcd_cs, running, ovf} !== {e.min, e.sec, e.cs, e.run, e.ovf}) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h:%h.%h run=%b ovf=%b, required %h:%h.%h run=%b ovf=%b",
                     e.name, bcd_min, bcd_sec, bcd_cs, running, ovf,
                     e.min, e.sec, e.cs, e.run, e.ovf);
        end
    endtask

    // All stimulus tasks start and end on a falling clock edge.
    task automatic ticks(input int n);
        tick_10ms = 1'b1;
        repeat (n) @(negedge clk);
        tick_10ms = 1'b0;
    endtask

    task automatic pressBtn(input int which, input int holdCycles);
        if (which == 0) btn_ss = 1'b1;
        else if (which == 1) btn_clr = 1'b1;
        else btn_lap = 1'b1;
        repeat (holdCycles) @(negedge clk);
        btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic applyStimulus(input int idx);
        vec_t v;
        v = vecs[idx];
        expectNow($sformatf("vec%0d", idx), v.min, v.sec, v.cs, v.run, 1'b0);
        case (v.act)
            ACT_TICKS: ticks(v.n);
            ACT_SS:    pressBtn(0, 5);
            default:   pressBtn(1, 5);
        endcase
        checkOutput();
    endtask

    initial begin
        vecs[0]  = '{ACT_TICKS, 5,    8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{ACT_SS,    0,    8'h00, 8'h00, 8'h00, 1'b1};
        vecs[2]  = '{ACT_TICKS, 150,  8'h00, 8'h01, 8'h50, 1'b1};
        vecs[3]  = '{ACT_SS,    0,    8'h00, 8'h01, 8'h50, 1'b0};
        vecs[4]  = '{ACT_TICKS, 20,   8'h00, 8'h01, 8'h50, 1'b0};
        vecs[5]  = '{ACT_SS,    0,    8'h00, 8'h01, 8'h50, 1'b1};
        vecs[6]  = '{ACT_TICKS, 1,    8'h00, 8'h01, 8'h51, 1'b1};
        vecs[7]  = '{ACT_TICKS, 49,   8'h00, 8'h02, 8'h00, 1'b1};
        vecs[8]  = '{ACT_TICKS, 5850, 8'h01, 8'h00, 8'h50, 1'b1};
        vecs[9]  = '{ACT_CLR,   0,    8'h00, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{ACT_SS,    0,    8'h00, 8'h00, 8'h00, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        expectNow("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput();

        for (int i = 0; i < 11; i++) applyStimulus(i);

        // Wrap from 01:59.99 with MIN_MAX=1.
        pressBtn(1, 3);
        pressBtn(0, 3);
        ticks(11999);
        expectNow("pre_wrap", 8'h01, 8'h59, 8'h99, 1'b1, 1'b0);
        checkOutput();
        ticks(1);
        expectNow("wrap", 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        checkOutput();
        @(negedge clk);
        expectNow("ovf_one_cycle", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        checkOutput();

        // Clear and tick land in the same cycle.
        pressBtn(1, 3);
        pressBtn(0, 3);
        ticks(1234);
        expectNow("at_12_34", 8'h00, 8'h12, 8'h34, 1'b1, 1'b0);
        checkOutput();
        btn_clr = 1'b1;
        repeat (3) @(negedge clk);
        expectNow("clr_latency", 8'h00, 8'h12, 8'h34, 1'b1, 1'b0);
        checkOutput();
        tick_10ms = 1'b1;
        @(negedge clk);
        tick_10ms = 1'b0;
        btn_clr = 1'b0;
        expectNow("clr_beats_tick", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput();
        repeat (4) @(negedge clk);

        // Start/stop with a coincident tick: tick applied, then pause.
        pressBtn(0, 3);
        ticks(7);
        btn_ss = 1'b1;
        repeat (3) @(negedge clk);
        tick_10ms = 1'b1;
        @(negedge clk);
        tick_10ms = 1'b0;
        btn_ss = 1'b0;
        expectNow("ss_with_tick", 8'h00, 8'h00, 8'h08, 1'b0, 1'b0);
        checkOutput();
        repeat (4) @(negedge clk);
        ticks(5);
        expectNow("paused_frozen", 8'h00, 8'h00, 8'h08, 1'b0, 1'b0);
        checkOutput();
        pressBtn(0, 20);
        expectNow("long_hold_one_event", 8'h00, 8'h00, 8'h08, 1'b1, 1'b0);
        checkOutput();
        ticks(1);
        expectNow("resume_tick", 8'h00, 8'h00, 8'h09, 1'b1, 1'b0);
        checkOutput();

        // Asynchronous reset between clock edges.
        pressBtn(1, 3);
        pressBtn(0, 3);
        ticks(6725);
        expectNow("at_01_07_25", 8'h01, 8'h07, 8'h25, 1'b1, 1'b0);
        checkOutput();
        #2 rst = 1'b1;
        #1;
        expectNow("async_reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
        ticks(10);
        expectNow("no_count_after_reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput();
        pressBtn(0, 3);
        ticks(3);
        expectNow("restart_after_reset", 8'h00, 8'h00, 8'h03, 1'b1, 1'b0);
        checkOutput();

`ifdef STOPWATCH_LAP_EN
        pressBtn(1, 3);
        pressBtn(0, 3);
        ticks(100);
        pressBtn(2, 3);
        ticks(100);
        expectNow("lap_held", 8'h00, 8'h01, 8'h00, 1'b1, 1'b0);
        checkOutput();
        pressBtn(2, 3);
        expectNow("lap_release", 8'h00, 8'h02, 8'h00, 1'b1, 1'b0);
        checkOutput();
        pressBtn(0, 3);
        pressBtn(2, 3);
        pressBtn(0, 3);
        ticks(1);
        expectNow("lap_ignored_in_pause", 8'h00, 8'h02, 8'h01, 1'b1, 1'b0);
        checkOutput();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd_counter.md
# stopwatch_bcd_counter

Stopwatch timekeeping core: counts elapsed time in BCD centiseconds, seconds and minutes under start/stop/clear button control. It sits directly upstream of the 2-digit BCD-to-7-segment drivers: each 8-bit BCD output pair feeds one `bcd_in` of a display digit-pair driver. It runs in the same clock domain, and a 10 ms tick from the shared pulse generator advances it.

## Interface
Parameters:
- `MIN_MAX`, default 59: highest minute value before wrap (BCD-legal, 1..99).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `tick_10ms` in 1: single-cycle enable, one per 10 ms.
- `btn_ss` in 1: start/stop button, raw level, asynchronous to `clk`.
- `btn_clr` in 1: clear button, raw level, asynchronous.
- `btn_lap` in 1: lap button, raw level, asynchronous. Ignored unless `STOPWATCH_LAP_EN` is defined.
- `bcd_cs` out 8: centiseconds, two BCD digits, [7:4] tens.
- `bcd_sec` out 8: seconds, two BCD digits.
- `bcd_min` out 8: minutes, two BCD digits.
- `running` out 1: high in RUN state.
- `ovf` out 1: one-cycle pulse on wrap from MIN_MAX:59.99 to 00:00.00.

## Operation
- Each button passes through a 2-FF synchronizer and then a rising-edge detector. One press produces one internal event pulse. Debounce is upstream's responsibility.
- FSM states: IDLE (zero, stopped), RUN, PAUSE.
  - IDLE + ss → RUN.
  - RUN + ss → PAUSE.
  - PAUSE + ss → RUN.
  - Any state + clr → IDLE.
- Counter advances only in RUN and only on `tick_10ms`.
- Digit chain:
  - cs ones 0–9 carries into cs tens 0–9.
  - cs tens carries into sec ones 0–9.
  - sec ones carries into sec tens 0–5.
  - sec tens carries into min ones 0–9.
  - min ones carries into min tens.
  - Minutes wrap to 00 after MIN_MAX.
- Carries ripple combinationally within one cycle. All six digits update in the same clock edge.
- Wrap: on a tick at MIN_MAX:59.99, all digits go to 0, `ovf` pulses high for 1 cycle, and the state stays RUN.
- Simultaneous events:
  - clr beats ss.
  - clr beats tick: count goes to 0 and the tick is discarded.
  - ss arriving in the same cycle as tick in RUN: the tick is applied, then the block moves to PAUSE.
- Every digit stays in BCD range at all times. Any out-of-range internal digit (e.g. after an upset) is forced to 0 on the next tick.

## Timing
- Reset values: all BCD outputs 8'h00, `running` 0, `ovf` 0, state IDLE, lap hold cleared.
- Reset asserted mid-run clears everything immediately (asynchronous). Counting resumes only after a fresh ss event.
- Button latency: a raw rising edge at cycle n is sampled into the sync chain. The edge pulse appears at n+2, and the state/count effect is visible at n+3.
- Tick latency: a tick sampled at edge k updates the outputs after edge k (registered outputs, 1 cycle).
- `running` changes in the same cycle as the FSM state.
- `ovf` is high exactly in the cycle after the wrapping tick.
- Holding a button high produces exactly one event. Releasing and pressing again produces another.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - In RUN, a lap event copies the live count into a hold register, and the outputs show the held value. The internal count keeps advancing.
  - A second lap event releases the hold, and the outputs return to the live count on the next cycle.
  - clr also releases the hold.
  - A lap event in IDLE or PAUSE is ignored.
  - `running` and `ovf` always reflect the live count.
- `STOPWATCH_LAP_EN` not defined: `btn_lap` is unused, no hold register is built, and the outputs always show the live count.

## Test plan
- Reset, then ss press, then 150 ticks → outputs sec=8'h01, cs=8'h50, `running`=1.
- In RUN, ss press, then 20 ticks → counts frozen, `running`=0. Next ss press plus 1 tick → cs increments by 1.
- Preload to 59:59.99 (MIN_MAX=59) in RUN, then 1 tick → all outputs 8'h00, `ovf` high for exactly 1 cycle, still RUN.
- clr and tick in the same cycle while in RUN at 00:12.34 → all outputs 8'h00, state IDLE, `running`=0.
- `rst` pulsed asynchronously between clock edges while in RUN at 03:07.25 → outputs 8'h00 before the next clk edge. No counting until the next ss press.
- `STOPWATCH_LAP_EN`: lap press at 00:01.00, then 100 ticks → outputs still read 00:01.00. Second lap press → outputs read 00:02.00.
